multiplier_core: RTL and testbench
==================================

// Module: multiplier_core
// PURPOSE
//   Iterative radix-2 shift-add integer multiplier for the datapath's MUL operation.
//   Computes the low WIDTH bits of X*Y in WIDTH cycles and flags unsigned overflow.
//   Operands are captured on a start pulse; the result is held until the next op.
//   Buses use big-endian bit numbering: [0:WIDTH-1], bit 0 = MSB.
// PARAMETERS
//   WIDTH  32  operand and result width in bits; must be >= 2
// PORTS
//   clk    in   1        rising-edge clock; the only clock
//   rst_n  in   1        synchronous, active-low reset
//   start  in   1        request a multiply; sampled only when busy=0
//   X      in   [0:W-1]  multiplicand; sampled when start is accepted
//   Y      in   [0:W-1]  multiplier; sampled when start is accepted
//   Z      out  [0:W-1]  low WIDTH bits of X*Y; registered, held between ops
//   ovf    out  1        1 = upper WIDTH bits of the unsigned 2W-bit product are non-zero
//   busy   out  1        1 while an operation is in progress
//   done   out  1        one-cycle pulse; Z and ovf are valid in that cycle
// BEHAVIOUR
// - Reset: rst_n=0 at a rising edge gives Z=0, ovf=0, busy=0, done=0, and clears all internal state.
//   Reset during an operation aborts it; no done pulse follows.
// - States: IDLE (busy=0) and RUN (busy=1).
// - IDLE, start=1 at edge E0: latch X and Y, clear the 2W-bit accumulator, set counter=0, go to RUN.
// - RUN, edges E1..EW: one iteration per edge.
//   - Add the shifted multiplicand when the current multiplier bit is 1.
//   - Start with the LSB (bit W-1 in big-endian numbering).
// - At edge EW: Z <= acc[low W bits], ovf <= |acc[high W bits], done <= 1, busy <= 0, go to IDLE.
//   Result latency is exactly WIDTH cycles after the accepting edge.
// - done is high for exactly one cycle and is 0 at every other time.
// - Z and ovf change only at the completing edge or on reset.
//   They hold their values while busy=1 and while idle.
// - start while busy=1: ignored; it is not queued and the operands are not re-sampled.
// - start=1 in the done cycle: busy=0 then, so the request is accepted back-to-back.
// - Arithmetic: unsigned. The low W bits also equal the two's-complement signed product.
//   ovf is defined on the unsigned interpretation only.
// - X or Y changing after the accepting edge has no effect on the op in flight.
// - Zero operands still take the full WIDTH cycles; there is no early termination.
// TESTING
//   1. X=20, Y=10, start 1 cycle -> WIDTH cycles later done=1, Z=0x000000C8, ovf=0.
//   2. X=0x01010101, Y=0x00000002 -> Z=0x02020202, ovf=0.
//      X=0x00000033, Y=0x00000003 -> Z=0x00000099, ovf=0.
//   3. X=0x11110000, Y=0xFFFF0000 -> Z=0x00000000, ovf=1.
//      X=0xFFFFFFFF, Y=0xFFFFFFFF -> Z=0x00000001, ovf=1.
//   4. Start with X=3, Y=5; re-pulse start with X=7, Y=7 mid-run and change X/Y
//      -> Z=15, done once; the second start is ignored.
//      Then start in the done cycle with X=7, Y=7 -> Z=49 after WIDTH more cycles.
//   5. Start with X=9, Y=9; drop rst_n at cycle 10 for 1 cycle
//      -> Z=0, ovf=0, busy=0, no done pulse; the next op X=2, Y=4 -> Z=8.
//   6. X=0, Y=0xFFFFFFFF -> done still at exactly WIDTH cycles, Z=0, ovf=0.
//      Z stays stable throughout the busy period.

Source files
------------

// File: rtl/multiplier_core.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_core
// Purpose  : Iterative radix-2 shift-add integer multiplier. It produces the
//            low WIDTH bits of X*Y in exactly WIDTH cycles after a start is
//            accepted. It also flags when the upper WIDTH bits of the unsigned
//            2*WIDTH-bit product are non-zero.
//
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous, active-low reset
//            start  - multiply request, only looked at while idle
//            X, Y   - operands [0:WIDTH-1], bit 0 is the MSB
//            Z      - low WIDTH bits of the product, held between ops
//            ovf    - upper half of the unsigned product is non-zero
//            busy   - operation in progress
//            done   - one-cycle pulse when Z/ovf are updated
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [0:WIDTH-1] X,
  input  logic [0:WIDTH-1] Y,
  output logic [0:WIDTH-1] Z,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int              c_cw   = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  // Internal arithmetic uses conventional [msb:lsb] vectors. A
  // whole-vector assignment between [0:W-1] and [W-1:0] is positional,
  // so the numeric value is preserved: X[0] (MSB) lands on w_x[WIDTH-1].
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_next;

  logic [0:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left one place per iteration
  logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right; bit 0 is the current bit
  logic [2*WIDTH-1:0] r_acc;
  logic [c_cw-1:0]    r_count;
  logic [0:WIDTH-1]   r_z;
  logic               r_ovf;
  logic               r_done;

  assign w_x        = X;
  assign w_y        = Y;
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_z      <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_x};
            r_mplier <= w_y;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= c_run;
          end
        end
        c_run: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + c_one;
          // The last iteration publishes the sum it is forming this cycle,
          // so the result lands exactly WIDTH edges after acceptance.
          if (r_count == c_last) begin
            r_z     <= w_acc_next[WIDTH-1:0];
            r_ovf   <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_done  <= 1'b1;
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign Z    = r_z;
  assign ovf  = r_ovf;
  assign busy = (r_state == c_run);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_core
// Purpose  : Self-checking bench for multiplier_core. It runs fixed vectors,
//            random operands against an arithmetic reference, and the
//            mid-run start, back-to-back and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_core;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [0:WIDTH-1] X;
  logic [0:WIDTH-1] Y;
  logic [0:WIDTH-1] Z;
  logic             ovf;
  logic             busy;
  logic             done;

  int n_vec;
  int n_err;

  multiplier_core #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        ovf;
  } vec_t;

  // Reference: full unsigned product from plain arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulses start for one edge, then follows the op to its done cycle.
  // It returns in the done cycle. It reports the latency and whether
  // busy/Z misbehaved while the op was running.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output int lat, output bit unstable);
    logic [0:WIDTH-1] z_hold;
    z_hold   = Z;
    unstable = 1'b0;
    X = x;
    Y = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < WIDTH + 4) begin
      if (busy !== 1'b1 || Z !== z_hold) unstable = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic op_and_check(input string name, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] exp_z, input logic exp_ovf);
    int lat;
    bit unstable;
    run_op(x, y, lat, unstable);
    check({name, " latency"}, 64'(lat), 64'(WIDTH));
    check({name, " Z"}, 64'(Z), 64'(exp_z));
    check({name, " ovf"}, 64'(ovf), 64'(exp_ovf));
    check({name, " busy-low-at-done"}, 64'(busy), 64'd0);
    check({name, " stable-while-busy"}, 64'(unstable), 64'd0);
  endtask

  initial begin
    vec_t        tbl[7];
    logic [63:0] p;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [0:WIDTH-1] z_prev;
    int          n_done;
    int          lat;
    bit          unstable;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    X     = '0;
    Y     = '0;

    tbl[0] = '{32'd20,        32'd10,        32'h000000C8, 1'b0};
    tbl[1] = '{32'h01010101,  32'h00000002,  32'h02020202, 1'b0};
    tbl[2] = '{32'h00000033,  32'h00000003,  32'h00000099, 1'b0};
    tbl[3] = '{32'h11110000,  32'hFFFF0000,  32'h00000000, 1'b1};
    tbl[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 1'b1};
    tbl[5] = '{32'h00000000,  32'hFFFFFFFF,  32'h00000000, 1'b0};
    tbl[6] = '{32'h00010000,  32'h00010000,  32'h00000000, 1'b1};

    // Reset state
    tick();
    tick();
    check("reset Z", 64'(Z), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fixed vectors
    for (int i = 0; i < 7; i++) begin
      op_and_check($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].ovf);
      z_prev = Z;
      tick();
      check($sformatf("tbl%0d done-one-cycle", i), 64'(done), 64'd0);
      check($sformatf("tbl%0d Z-held-idle", i), 64'(Z), 64'(z_prev));
    end

    // Random operands against the reference product
    for (int i = 0; i < 20; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 3 == 0) begin
        rx = rx & 32'h0000FFFF;
        ry = ry & 32'h0000FFFF;
      end
      p = ref_prod(rx, ry);
      op_and_check($sformatf("rand%0d", i), rx, ry, p[31:0], |p[63:32]);
    end
    tick();

    // Start re-pulsed mid-run and operands changed: both must be ignored
    X = 32'd3;
    Y = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= WIDTH; c++) begin
      if (c == 5) begin
        X = 32'd7;
        Y = 32'd7;
        start = 1'b1;
      end else if (c == 6) begin
        start = 1'b0;
        X = 32'hAAAA5555;
        Y = 32'h12345678;
      end
      tick();
      if (done === 1'b1) n_done++;
    end
    check("midstart done", 64'(done), 64'd1);
    check("midstart Z", 64'(Z), 64'd15);
    check("midstart ovf", 64'(ovf), 64'd0);
    check("midstart done-count", 64'(n_done), 64'd1);

    // Back-to-back: start raised in the done cycle is accepted
    op_and_check("back2back", 32'd7, 32'd7, 32'd49, 1'b0);
    tick();

    // Reset during an op aborts it with no done pulse
    X = 32'd9;
    Y = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort Z", 64'(Z), 64'd0);
    check("abort ovf", 64'(ovf), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    n_done = 0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check("abort no-activity", 64'(n_done), 64'd0);
    op_and_check("after-abort", 32'd2, 32'd4, 32'd8, 1'b0);

    // Another op run directly to cover the raw task path
    run_op(32'hFFFF, 32'hFFFF, lat, unstable);
    check("raw latency", 64'(lat), 64'(WIDTH));
    check("raw Z", 64'(Z), 64'hFFFE0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
